// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C master arbiter slice.
package i2c_arb_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 16;
  localparam int N_REQ_MAX  = 8;
  localparam int IDX_W      = $clog2(N_REQ_MAX);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Round-robin successor, wrapping from n_req-1 back to 0.
  function automatic idx_t next_idx(input idx_t idx, input int n_req);
    return (int'(idx) == n_req - 1) ? '0 : idx + idx_t'(1);
  endfunction
endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Requester-side and master-side signals of the arbiter; master modport is the arbiter's view.
interface i2c_master_arbiter_if #(parameter int N_REQ = 4);
  import i2c_arb_pkg::*;

  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0]            req_rnw;
  logic [I2C_ADDR_W*N_REQ-1:0] req_addr;
  logic [I2C_DATA_W*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]            gnt;
  logic [N_REQ-1:0]            ack;
  logic [N_REQ-1:0]            err;
  logic [I2C_DATA_W-1:0]       rd_data;
  logic                        busy;

  logic                        mst_start_stb;
  logic                        mst_rnw;
  logic [I2C_ADDR_W-1:0]       mst_addr;
  logic [I2C_DATA_W-1:0]       mst_wdata;
  logic                        mst_done;
  logic [I2C_DATA_W-1:0]       mst_rd_data;
  logic                        mst_abort;

  modport master (
    input  req, req_rnw, req_addr, req_wdata, mst_done, mst_rd_data,
    output gnt, ack, err, rd_data, busy,
           mst_start_stb, mst_rnw, mst_addr, mst_wdata, mst_abort
  );

  modport slave (
    output req, req_rnw, req_addr, req_wdata, mst_done, mst_rd_data,
    input  gnt, ack, err, rd_data, busy,
           mst_start_stb, mst_rnw, mst_addr, mst_wdata, mst_abort
  );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping to the lowest set bit.
module rr_priority_picker
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  idx_t             ptr,
  output idx_t             idx,
  output logic             vld
);
  idx_t lo_idx;
  idx_t hi_idx;
  logic hi_vld;

  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    hi_vld = 1'b0;
    vld    = 1'b0;
    // Descending scan so the lowest qualifying index is the one left standing.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = idx_t'(i);
        vld    = 1'b1;
      end
      if (req[i] && (idx_t'(i) >= ptr)) begin
        hi_idx = idx_t'(i);
        hi_vld = 1'b1;
      end
    end
    idx = hi_vld ? hi_idx : lo_idx;
  end
endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin share of one I2C master; grant/strobe 1 cycle after req, ack 1 cycle after mst_done, req held as a level until ack/err.
// Define I2C_ARB_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT_CYC cycles (err + mst_abort instead of ack).
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic                  clk,
  input logic                  rst,
  i2c_master_arbiter_if.master bus
);
  if (N_REQ < 2 || N_REQ > N_REQ_MAX || TIMEOUT_CYC < 2) begin : g_param_check
    $error("i2c_master_arbiter: illegal N_REQ or TIMEOUT_CYC");
  end

  state_t                state_q, state_d;
  idx_t                  ptr_q, ptr_d;
  idx_t                  idx_q, idx_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic [N_REQ-1:0]      ack_q, ack_d;
  logic [I2C_DATA_W-1:0] rd_q, rd_d;
  logic                  busy_q, busy_d;
  logic                  stb_q, stb_d;
  logic                  rnw_q, rnw_d;
  logic [I2C_ADDR_W-1:0] addr_q, addr_d;
  logic [I2C_DATA_W-1:0] wdata_q, wdata_d;

  idx_t                  pick_idx;
  logic                  pick_vld;
  logic                  sel_rnw;
  logic [I2C_ADDR_W-1:0] sel_addr;
  logic [I2C_DATA_W-1:0] sel_wdata;
  logic [N_REQ-1:0]      sel_onehot;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC) > 12) ? $clog2(TIMEOUT_CYC) : 12;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic             abort_q, abort_d;
`endif

  rr_priority_picker #(.N_REQ(N_REQ)) u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_comb begin
    sel_rnw    = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (idx_t'(i) == pick_idx) begin
        sel_rnw       = bus.req_rnw[i];
        sel_addr      = bus.req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
        sel_wdata     = bus.req_wdata[i*I2C_DATA_W +: I2C_DATA_W];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    rd_d    = rd_q;
    stb_d   = 1'b0;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = '0;
    abort_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          idx_d   = pick_idx;
          gnt_d   = sel_onehot;
          rnw_d   = sel_rnw;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          stb_d   = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        // A completion in the timeout cycle still counts as a normal finish.
        if (bus.mst_done) begin
          state_d = DONE;
          ack_d   = gnt_q;
          if (rnw_q) rd_d = bus.mst_rd_data;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = DONE;
          err_d   = gnt_q;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = next_idx(idx_q, N_REQ);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= '0;
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      abort_q <= abort_d;
`endif
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.ack           = ack_q;
  assign bus.rd_data       = rd_q;
  assign bus.busy          = busy_q;
  assign bus.mst_start_stb = stb_q;
  assign bus.mst_rnw       = rnw_q;
  assign bus.mst_addr      = addr_q;
  assign bus.mst_wdata     = wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
  assign bus.err           = err_q;
  assign bus.mst_abort     = abort_q;
`else
  assign bus.err           = '0;
  assign bus.mst_abort     = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter: directed requests push expected start/ack/err events; a monitor pops and checks them.
module tb_i2c_master_arbiter;
  import i2c_arb_pkg::*;

  localparam int NR = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2c_master_arbiter_if #(.N_REQ(NR)) bus();

  i2c_master_arbiter #(.N_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    int          kind;   // 0 start, 1 ack, 2 err
    int          idx;
    logic        rnw;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rd;
    int          cyc;    // absolute start cycle, or -1 for "two cycles after previous ack"
  } ev_t;

  ev_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_start_cyc = -100;
  int last_ack_cyc = -100;
  int last_done_cyc = -100;
  int starts_seen = 0;

  bit          mdl_en = 1'b0;
  int          mdl_delay = 1;
  logic [15:0] mdl_base = '0;
  int          mdl_cnt = 0;
  logic [15:0] mdl_data = '0;
  int          stray_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic push_start(input int idx, input logic rnw, input logic [6:0] addr,
                            input logic [15:0] wdata, input int c);
    ev_t e;
    e.kind = 0; e.idx = idx; e.rnw = rnw; e.addr = addr; e.wdata = wdata; e.rd = '0; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic push_end(input int kind, input int idx, input logic [6:0] addr, input logic [15:0] rd);
    ev_t e;
    e.kind = kind; e.idx = idx; e.rnw = 1'b0; e.addr = addr; e.wdata = '0; e.rd = rd; e.cyc = -1;
    q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic rnw, input logic [6:0] addr, input logic [15:0] wdata);
    bus.req_rnw[i] = rnw;
    bus.req_addr[i*7 +: 7] = addr;
    bus.req_wdata[i*16 +: 16] = wdata;
    bus.req[i] = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((q.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (starts_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_starts", 32'(n < budget), 32'd1);
  endtask

  // I2C master model: answers a start strobe with mst_done after mdl_delay cycles.
  initial begin
    bus.mst_done = 1'b0;
    bus.mst_rd_data = 16'hDEAD;
    forever begin
      @(negedge clk);
      bus.mst_done = 1'b0;
      bus.mst_rd_data = 16'hDEAD;
      if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin
          bus.mst_done = 1'b1;
          bus.mst_rd_data = mdl_data;
          last_done_cyc = cyc;
        end
      end
      if (cyc == stray_cyc) begin
        bus.mst_done = 1'b1;
        bus.mst_rd_data = 16'h7777;
      end
      if (bus.mst_start_stb && mdl_en) begin
        mdl_cnt = mdl_delay;
        mdl_data = mdl_base + {9'b0, bus.mst_addr};
      end
    end
  end

  // Monitor: invariants every cycle, scoreboard pop on each start/ack/err.
  initial begin
    bit prev_stb = 1'b0;
    ev_t e;
    forever begin
      @(negedge clk);
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      chk("ack_onehot0", 32'($onehot0(bus.ack)), 32'd1);
      chk("err_onehot0", 32'($onehot0(bus.err)), 32'd1);
      chk("stb_back_to_back", 32'(prev_stb && bus.mst_start_stb), 32'd0);
      chk("abort_matches_err", 32'(bus.mst_abort), 32'(|bus.err));
      prev_stb = bus.mst_start_stb;
      if (bus.mst_start_stb) begin
        if (q.size() == 0) chk("unexpected_start", 32'(bus.gnt), 32'd0);
        else begin
          e = q.pop_front();
          chk("start_kind", 32'(e.kind), 32'd0);
          chk("start_gnt", 32'(bus.gnt), 32'(1) << e.idx);
          chk("start_rnw", 32'(bus.mst_rnw), 32'(e.rnw));
          chk("start_addr", 32'(bus.mst_addr), 32'(e.addr));
          chk("start_wdata", 32'(bus.mst_wdata), 32'(e.wdata));
          if (e.cyc >= 0) chk("start_cycle", 32'(cyc), 32'(e.cyc));
          else chk("start_after_ack", 32'(cyc), 32'(last_ack_cyc + 2));
        end
        last_start_cyc = cyc;
        starts_seen++;
      end
      if (|bus.ack) begin
        if (q.size() == 0) chk("unexpected_ack", 32'(bus.ack), 32'd0);
        else begin
          e = q.pop_front();
          chk("ack_kind", 32'(e.kind), 32'd1);
          chk("ack_vec", 32'(bus.ack), 32'(1) << e.idx);
          chk("ack_gnt_held", 32'(bus.gnt), 32'(1) << e.idx);
          chk("ack_rd_data", 32'(bus.rd_data), 32'(e.rd));
          chk("ack_addr_held", 32'(bus.mst_addr), 32'(e.addr));
          chk("ack_cycle", 32'(cyc), 32'(last_done_cyc + 1));
        end
        last_ack_cyc = cyc;
      end
      if (|bus.err) begin
        if (q.size() == 0) chk("unexpected_err", 32'(bus.err), 32'd0);
        else begin
          e = q.pop_front();
          chk("err_kind", 32'(e.kind), 32'd2);
          chk("err_vec", 32'(bus.err), 32'(1) << e.idx);
          chk("err_no_ack", 32'(bus.ack), 32'd0);
          chk("err_rd_data", 32'(bus.rd_data), 32'(e.rd));
          chk("err_cycle", 32'(cyc), 32'(last_start_cyc + TO + 1));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] fair_rd [5];
    int          fair_idx [5];
    bus.req = '0; bus.req_rnw = '0; bus.req_addr = '0; bus.req_wdata = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_stb", 32'(bus.mst_start_stb), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_mst_fields", {bus.mst_rnw, bus.mst_addr, bus.mst_wdata}, 32'd0);
    chk("rst_ack_err", {bus.ack, bus.err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single write from requester 2, master finishes 20 cycles after the strobe.
    mdl_en = 1'b1; mdl_delay = 20; mdl_base = 16'h0000;
    set_req(2, 1'b0, 7'h2A, 16'hBEEF);
    push_start(2, 1'b0, 7'h2A, 16'hBEEF, cyc + 1);
    push_end(1, 2, 7'h2A, 16'h0000);
    @(negedge clk); bus.req[2] = 1'b0;
    drain("drain_write", 100);

    // mst_done while idle must be ignored.
    stray_cyc = cyc + 1;
    repeat (3) @(negedge clk);
    chk("stray_busy", 32'(bus.busy), 32'd0);
    chk("stray_rd_data", 32'(bus.rd_data), 32'd0);

    // ptr=3: only requester 0 pending, wraps; read returns 1234.
    mdl_delay = 5; mdl_base = 16'h11E4;
    set_req(0, 1'b1, 7'h50, 16'h0000);
    push_start(0, 1'b1, 7'h50, 16'h0000, cyc + 1);
    push_end(1, 0, 7'h50, 16'h1234);
    @(negedge clk); bus.req[0] = 1'b0;
    drain("drain_read", 100);

    // ptr=1 with req=0101: 2 wins, then 0 after wrap.
    mdl_base = 16'h1111;
    set_req(0, 1'b0, 7'h05, 16'h0005);
    set_req(2, 1'b0, 7'h07, 16'h0007);
    push_start(2, 1'b0, 7'h07, 16'h0007, cyc + 1);
    push_end(1, 2, 7'h07, 16'h1234);
    push_start(0, 1'b0, 7'h05, 16'h0005, -1);
    push_end(1, 0, 7'h05, 16'h1234);
    @(negedge clk); bus.req[2] = 1'b0;
    wait_starts(starts_seen + 1, 100);
    bus.req[0] = 1'b0;
    drain("drain_ptr", 100);

    // Reset during WAIT: no ack, everything clears.
    mdl_en = 1'b0;
    set_req(1, 1'b0, 7'h21, 16'h2121);
    push_start(1, 1'b0, 7'h21, 16'h2121, cyc + 1);
    @(negedge clk); bus.req[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_in_wait", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_gnt", 32'(bus.gnt), 32'd0);
    chk("midrst_ack", 32'(bus.ack), 32'd0);
    chk("midrst_rd_data", 32'(bus.rd_data), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Fairness from ptr=0 with all four requesting; odd requesters read.
    mdl_en = 1'b1; mdl_delay = 3; mdl_base = 16'hC000;
    fair_idx = '{0, 1, 2, 3, 0};
    fair_rd  = '{16'h0000, 16'hC011, 16'hC011, 16'hC013, 16'hC013};
    for (int i = 0; i < NR; i++) set_req(i, i[0], 7'h10 + 7'(i), 16'hA000 + 16'(i));
    for (int k = 0; k < 5; k++) begin
      push_start(fair_idx[k], fair_idx[k][0], 7'h10 + 7'(fair_idx[k]), 16'hA000 + 16'(fair_idx[k]),
                 (k == 0) ? cyc + 1 : -1);
      push_end(1, fair_idx[k], 7'h10 + 7'(fair_idx[k]), fair_rd[k]);
    end
    wait_starts(starts_seen + 5, 200);
    bus.req = '0;
    bus.req_addr = '1;
    drain("drain_fair", 100);

    // Master never answers.
    mdl_en = 1'b0;
    set_req(3, 1'b0, 7'h33, 16'h3333);
    push_start(3, 1'b0, 7'h33, 16'h3333, cyc + 1);
`ifdef I2C_ARB_TIMEOUT_EN
    push_end(2, 3, 7'h33, 16'hC013);
    @(negedge clk); bus.req[3] = 1'b0;
    drain("drain_timeout", 100);
`else
    @(negedge clk); bus.req[3] = 1'b0;
    repeat (10000) @(negedge clk);
    chk("no_timeout_busy", 32'(bus.busy), 32'd1);
    chk("no_timeout_gnt", 32'(bus.gnt), 32'b1000);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
`endif

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
